// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle RV32I control unit.
// Holds the FSM state enum, the RV32I opcode constants, the datapath mux-select
// encodings and the per-state control-word table used by multicycle_control.
package ctrl_pkg;

    localparam int unsigned STATE_W  = 5;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_EXEC_R   = 5'd3,
        S_EXEC_I   = 5'd4,
        S_AUIPC    = 5'd5,
        S_WB_ALU   = 5'd6,
        S_MEM_ADDR = 5'd7,
        S_MEM_RD   = 5'd8,
        S_WB_MEM   = 5'd9,
        S_MEM_WR   = 5'd10,
        S_BRANCH   = 5'd11,
        S_JAL      = 5'd12,
        S_JALR     = 5'd13,
        S_LUI      = 5'd14,
        S_ILLEGAL  = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    // RV32I major opcodes (IR[6:0])
    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

    // Writeback source
    localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;
    localparam logic [SEL_W-1:0] M2R_IMM    = 2'b11;

    // ALU operand A
    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b10;

    // ALU operand B
    localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;

    // PC source
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;

    // ALU operation class
    localparam logic [SEL_W-1:0] ALUOP_ADD    = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [SEL_W-1:0] ALUOP_ITYPE  = 2'b11;

    // Registered control word; the *_on_ready bits are qualified by mem_ready
    // in the same cycle so that completion strobes fire only on the ready beat.
    typedef struct packed {
        logic             pc_write;
        logic             pc_write_cond;
        logic             fetch_on_ready;
        logic             i_or_d;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic [SEL_W-1:0] mem_to_reg;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_source;
        logic             instr_done;
        logic             done_on_ready;
    } ctrl_t;

    // Opcode to first execution state; unknown opcodes map to S_ILLEGAL
    function automatic state_t decode_state(input logic [OPCODE_W-1:0] op);
        state_t s;
        case (op)
            OP_R:               s = S_EXEC_R;
            OP_IMM:             s = S_EXEC_I;
            OP_LOAD, OP_STORE:  s = S_MEM_ADDR;
            OP_BRANCH:          s = S_BRANCH;
            OP_JAL:             s = S_JAL;
            OP_JALR:            s = S_JALR;
            OP_LUI:             s = S_LUI;
            OP_AUIPC:           s = S_AUIPC;
            default:            s = S_ILLEGAL;
        endcase
        return s;
    endfunction

    // Moore control word for each state
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read       = 1'b1;
                c.i_or_d         = 1'b0;
                c.alu_src_a      = SRCA_PC;
                c.alu_src_b      = SRCB_FOUR;
                c.alu_op         = ALUOP_ADD;
                c.pc_source      = PCSRC_ALU;
                c.fetch_on_ready = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_RTYPE;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ITYPE;
            end
            S_AUIPC: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_ALUOUT;
                c.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_MDR;
                c.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write     = 1'b1;
                c.i_or_d        = 1'b1;
                c.done_on_ready = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = SRCA_RS1;
                c.alu_src_b     = SRCB_RS2;
                c.alu_op        = ALUOP_BRANCH;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.instr_done    = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                c.pc_write   = 1'b1;
                c.pc_source  = PCSRC_ALUOUT;
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_PC;
                c.instr_done = 1'b1;
            end
            S_JALR: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_IMM;
                c.alu_op     = ALUOP_ADD;
                c.pc_write   = 1'b1;
                c.pc_source  = PCSRC_ALU;
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_PC;
                c.instr_done = 1'b1;
            end
            S_LUI: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_IMM;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-unit <-> datapath/memory signal bundle.
//   master (control unit): in opcode, mem_ready, zero; out all strobes/selects,
//                          illegal_instr, bus_error, state.
//   slave  (datapath side): the mirror image.
interface multicycle_control_if #(
    parameter int unsigned ALUOP_W = 2
);
    logic [6:0]         opcode;
    logic               mem_ready;
    logic               zero;
    logic               pc_write;
    logic               pc_write_cond;
    logic               ir_write;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         mem_to_reg;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_source;
    logic               instr_done;
    logic               illegal_instr;
    logic               bus_error;
    logic [4:0]         state;

    modport master (
        input  opcode, mem_ready, zero,
        output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               instr_done, illegal_instr, bus_error, state
    );

    modport slave (
        output opcode, mem_ready, zero,
        input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               instr_done, illegal_instr, bus_error, state
    );
endinterface

// File: rtl/mem_wait_watchdog.sv
// mem_wait_watchdog: counts consecutive memory wait cycles.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the counter (takes priority over enable)
//   enable    : a wait cycle is in progress (memory state, mem_ready low)
//   expire    : this wait cycle is the MAX_WAIT-th; 0 forever when MAX_WAIT = 0
module mem_wait_watchdog #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CNT_W-1:0] count;

    // Saturating wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(MAX_WAIT))) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires in the cycle whose increment would reach MAX_WAIT
    generate
        if (MAX_WAIT == 0) begin : g_disabled
            assign expire = 1'b0;
        end else begin : g_enabled
            assign expire = enable && (count == CNT_W'(MAX_WAIT - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore-style sequencer for the multi-cycle RV32I core.
//   clk, rst : clock, synchronous active-high reset
//   bus      : multicycle_control_if.master -- opcode/mem_ready/zero in;
//              PC/IR/memory/regfile strobes, mux selects, alu_op,
//              instr_done, illegal_instr, bus_error and debug state out.
// Control outputs are registered from the next state; ir_write, the fetch
// pc_write and the store instr_done are additionally gated by mem_ready.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT        = 16,
    parameter int unsigned TRAP_ON_ILLEGAL = 1,
    parameter int unsigned ALUOP_W         = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_if.master        bus
);

    state_t state_q;
    state_t next_state;
    ctrl_t  ctrl_q;
    logic   illegal_q;
    logic   bus_error_q;
    logic   opcode_illegal;
    logic   in_mem_state;
    logic   mem_wait;
    logic   wd_expire;
    logic   unused_zero;

    // Branch resolution against zero happens in the datapath via pc_write_cond
    assign unused_zero = bus.zero;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                          (state_q == S_MEM_WR);
    assign mem_wait     = in_mem_state && !bus.mem_ready;

    // Counter is zero on entry to any memory state: it is held clear whenever
    // no wait cycle is in progress, including the completing cycle.
    mem_wait_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!mem_wait),
        .enable (mem_wait),
        .expire (wd_expire)
    );

    // Next-state selection
    always_comb begin
        next_state     = state_q;
        opcode_illegal = 1'b0;
        unique case (state_q)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready)  next_state = S_DECODE;
                else if (wd_expire) next_state = S_TRAP;
            end
            S_DECODE: begin
                next_state = decode_state(bus.opcode);
                if (next_state == S_ILLEGAL) begin
                    opcode_illegal = 1'b1;
                    if (TRAP_ON_ILLEGAL != 0) next_state = S_TRAP;
                end
            end
            S_EXEC_R, S_EXEC_I, S_AUIPC: next_state = S_WB_ALU;
            // opcode bit 5 separates store (0100011) from load (0000011)
            S_MEM_ADDR: next_state = bus.opcode[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready)  next_state = S_WB_MEM;
                else if (wd_expire) next_state = S_TRAP;
            end
            S_MEM_WR: begin
                if (bus.mem_ready)  next_state = S_FETCH;
                else if (wd_expire) next_state = S_TRAP;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_LUI, S_ILLEGAL:
                next_state = S_FETCH;
            S_TRAP: next_state = S_TRAP;
            default: next_state = S_IDLE;
        endcase
    end

    // State, registered control word and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= next_state;
            ctrl_q      <= ctrl_for(next_state);
            // sticky in trap mode, otherwise a single-cycle pulse
            illegal_q   <= opcode_illegal || (illegal_q && (TRAP_ON_ILLEGAL != 0));
            // mem_ready in the expiry cycle suppresses wd_expire via mem_wait
            bus_error_q <= bus_error_q || wd_expire;
        end
    end

    assign bus.pc_write      = ctrl_q.pc_write || (ctrl_q.fetch_on_ready && bus.mem_ready);
    assign bus.ir_write      = ctrl_q.fetch_on_ready && bus.mem_ready;
    assign bus.pc_write_cond = ctrl_q.pc_write_cond;
    assign bus.i_or_d        = ctrl_q.i_or_d;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.alu_op        = ALUOP_W'(ctrl_q.alu_op);
    assign bus.pc_source     = ctrl_q.pc_source;
    assign bus.instr_done    = ctrl_q.instr_done || (ctrl_q.done_on_ready && bus.mem_ready);
    assign bus.illegal_instr = illegal_q;
    assign bus.bus_error     = bus_error_q;
    assign bus.state         = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-FSM control unit for the multi-cycle RV32I core. Replaces the single-cycle opcode decoder with a sequenced one. Drives fetch, decode, execute, memory and writeback steps over several clocks on a shared datapath. Adds memory wait-state handshake, JALR/AUIPC, illegal-opcode trap and a memory watchdog.

Parameters:
- MAX_WAIT, 16, max cycles to hold in any memory state awaiting mem_ready; 0 disables the watchdog.
- TRAP_ON_ILLEGAL, 1, 1 = illegal opcode enters sticky TRAP; 0 = one-cycle illegal_instr pulse, then FETCH.
- ALUOP_W, 2, alu_op width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- zero  in  1  branch-compare result from the ALU
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- ir_write  out  1  latch IR and old_pc
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  register-file write
- mem_to_reg  out  2  writeback source: 00 ALUOut, 01 MDR, 10 PC, 11 imm
- alu_src_a  out  2  ALU A: 00 PC, 01 rs1, 10 old_pc
- alu_src_b  out  2  ALU B: 00 rs2, 01 const 4, 10 imm
- alu_op  out  ALUOP_W  00 add, 01 branch compare, 10 R-type funct decode, 11 I-type funct decode
- pc_source  out  2  00 ALU result, 01 ALUOut
- instr_done  out  1  one-cycle pulse on the last state of each instruction
- illegal_instr  out  1  illegal opcode flag
- bus_error  out  1  watchdog expiry flag, sticky
- state  out  5  current state, for debug

Behaviour:
- Reset is synchronous and active-high.
- rst=1: state←IDLE, wait counter←0, illegal_instr←0, bus_error←0.
- All outputs are 0 in IDLE. rst mid-instruction aborts the instruction at the next edge; no partial strobes continue.
- IDLE → FETCH, unconditional.
- FETCH: mem_read=1, i_or_d=0, a=00, b=01, op=00, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1.
  - Holds while mem_ready=0. mem_ready=1 → DECODE.
- DECODE: a=10, b=10, op=00 (old_pc+imm→ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other opcode → ILLEGAL handling
- EXEC_R: a=01, b=00, op=10 → WB_ALU.
- EXEC_I: a=01, b=10, op=11 → WB_ALU.
- AUIPC: a=10, b=10, op=00 → WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=00, instr_done=1 → FETCH.
- MEM_ADDR: a=01, b=10, op=00. Next: load → MEM_RD, store → MEM_WR (opcode bit 5).
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then → WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=01, instr_done=1 → FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then instr_done=1 in that cycle → FETCH.
- BRANCH: a=01, b=00, op=01, pc_write_cond=1, pc_source=01, instr_done=1 → FETCH.
- JAL: pc_write=1, pc_source=01, reg_write=1, mem_to_reg=10, instr_done=1 → FETCH.
  - PC already holds the return address (PC+4) from FETCH.
- JALR: a=01, b=10, op=00, pc_write=1, pc_source=00, reg_write=1, mem_to_reg=10, instr_done=1 → FETCH.
  - The datapath clears bit 0 of the target.
- LUI: reg_write=1, mem_to_reg=11, instr_done=1 → FETCH.
- ILLEGAL handling:
  - TRAP_ON_ILLEGAL=1: → TRAP. illegal_instr=1, sticky, all strobes 0, exit only by rst.
  - TRAP_ON_ILLEGAL=0: illegal_instr pulses for 1 cycle in DECODE's successor, then → FETCH, no state change in the datapath.
- Watchdog:
  - Counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle in those states with mem_ready=0.
  - When the counter reaches MAX_WAIT with mem_ready still 0 → TRAP; bus_error=1, sticky.
  - mem_ready=1 in the expiry cycle wins: normal completion, no error.
  - Counter saturates and never wraps. Width is clog2(MAX_WAIT+1).
- Zero-wait latencies:
  - BRANCH/JAL/JALR/LUI: 3 cycles
  - R-type, I-type, AUIPC, store: 4 cycles
  - load: 5 cycles
  - Each wait cycle adds 1.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - mux-select encodings for mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op
- One sub-module, mem_wait_watchdog: counter, clear/enable inputs, expire output.

Test Plan:
- rst held 3 cycles, then released with opcode=0110011 and mem_ready=1 → IDLE, FETCH, DECODE, EXEC_R, WB_ALU; reg_write=1 only in the 5th post-reset cycle; instr_done pulses once.
- Load (0000011), mem_ready low for 2 cycles in MEM_RD → mem_read held 3 cycles with i_or_d=1; WB_MEM has mem_to_reg=01; 7 cycles total from FETCH.
- Branch (1100011) with zero=1, then zero=0 → pc_write_cond=1 and pc_source=01 in BRANCH both times; 3 cycles each.
- opcode=1111111 with TRAP_ON_ILLEGAL=1 → TRAP; illegal_instr stays 1 for 10 cycles; all strobes 0; rst returns to IDLE.
- MAX_WAIT=4, mem_ready stuck 0 in FETCH → TRAP after 4 wait cycles with bus_error=1; repeat with mem_ready=1 on the 4th cycle → DECODE, bus_error=0.
- JALR (1100111) then AUIPC (0010111) → JALR: pc_write=1, pc_source=00, mem_to_reg=10. AUIPC: a=10, b=10, then WB_ALU.
